// File: rtl/regfile_wb_arbiter.sv
// Two-port (EX/LD) writeback arbiter for the single regfile write port, with compressed-address
// mapping and cold-register authorization. Define COLD_ERR_CNT_EN to add the dropped-write counter.
module regfile_wb_hold #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy_en_i,
  input  logic            valid_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            is_16_i,
  input  logic            cold_en_i,
  input  logic            gnt_i,
  output logic            ready_o,
  output logic            take_o,
  output logic            held_o,
  output logic [4:0]      eaddr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            cold_o
);
  // a granted entry frees its slot in the same cycle, allowing back-to-back accepts
  assign ready_o = rdy_en_i & (~held_o | gnt_i);
  assign take_o  = valid_i & ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_o  <= 1'b0;
      eaddr_o <= '0;
      wdata_o <= '0;
      cold_o  <= 1'b0;
    end else if (take_o) begin
      held_o  <= 1'b1;
      eaddr_o <= is_16_i ? {2'b01, waddr_i[2:0]} : waddr_i;
      wdata_o <= wdata_i;
      cold_o  <= cold_en_i;
    end else if (gnt_i) begin
      held_o  <= 1'b0;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int          XLEN      = 64,
  parameter logic [31:0] COLD_MASK = 32'hFFFE_3018
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_waddr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_is_16_i,
  input  logic            ex_cold_en_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [4:0]      ld_waddr_i,
  input  logic [XLEN-1:0] ld_wdata_i,
  input  logic            ld_is_16_i,
  input  logic            ld_cold_en_i,
  output logic [4:0]      waddr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            regwrite_o,
  output logic            cold_en_o,
  output logic            cold_err_o,
  input  logic            cold_err_clr_i,
  output logic            busy_o
`ifdef COLD_ERR_CNT_EN
  , output logic [7:0]    cold_err_cnt_o
`endif
);
  localparam int NUM_PORTS = 2;  // index 0 = EX, 1 = LD

  logic                            rdy_en;
  logic [NUM_PORTS-1:0]            valid, is_16, cold_in, gnt, ready, take, held, cold_q;
  logic [NUM_PORTS-1:0][4:0]       waddr, eaddr;
  logic [NUM_PORTS-1:0][XLEN-1:0]  wdata_in, wdata_q;
  logic                            ex_older, ld_older, rr;

  assign valid    = {ld_valid_i,   ex_valid_i};
  assign is_16    = {ld_is_16_i,   ex_is_16_i};
  assign cold_in  = {ld_cold_en_i, ex_cold_en_i};
  assign waddr    = {ld_waddr_i,   ex_waddr_i};
  assign wdata_in = {ld_wdata_i,   ex_wdata_i};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      regfile_wb_hold #(.XLEN(XLEN)) u_hold (
        .clk(clk), .rst_n(rst_n), .rdy_en_i(rdy_en),
        .valid_i(valid[p]), .waddr_i(waddr[p]), .wdata_i(wdata_in[p]),
        .is_16_i(is_16[p]), .cold_en_i(cold_in[p]), .gnt_i(gnt[p]),
        .ready_o(ready[p]), .take_o(take[p]), .held_o(held[p]),
        .eaddr_o(eaddr[p]), .wdata_o(wdata_q[p]), .cold_o(cold_q[p])
      );
    end
  endgenerate

  assign ex_ready_o = ready[0];
  assign ld_ready_o = ready[1];
  assign busy_o     = |held;

  // rr == 0 points at EX; only consulted when both entries have equal age
  logic both;
  assign both   = held[0] & held[1];
  assign gnt[0] = held[0] & (~held[1] | ex_older | (~ld_older & ~rr));
  assign gnt[1] = held[1] & ~gnt[0];

  logic            any_gnt, g_cold, drop_cold, do_write;
  logic [4:0]      g_addr;
  logic [XLEN-1:0] g_data;

  assign any_gnt   = |gnt;
  assign g_addr    = gnt[1] ? eaddr[1]   : eaddr[0];
  assign g_data    = gnt[1] ? wdata_q[1] : wdata_q[0];
  assign g_cold    = gnt[1] ? cold_q[1]  : cold_q[0];
  assign drop_cold = any_gnt & COLD_MASK[g_addr] & ~g_cold;
  assign do_write  = any_gnt & (g_addr != 5'd0) & ~drop_cold;

  logic nh_ex, nh_ld;
  assign nh_ex = take[0] | (held[0] & ~gnt[0]);
  assign nh_ld = take[1] | (held[1] & ~gnt[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      ex_older <= 1'b0;
      ld_older <= 1'b0;
      rr       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (both) rr <= ~rr;
      // a fresh capture is always younger than whatever stays held on the other port
      if (take[0] && take[1]) begin
        ex_older <= 1'b0;
        ld_older <= 1'b0;
      end else if (take[0]) begin
        ex_older <= 1'b0;
        ld_older <= nh_ld;
      end else if (take[1]) begin
        ex_older <= nh_ex;
        ld_older <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_o    <= '0;
      wdata_o    <= '0;
      regwrite_o <= 1'b0;
      cold_en_o  <= 1'b0;
      cold_err_o <= 1'b0;
    end else begin
      regwrite_o <= do_write;
      if (do_write) begin
        waddr_o   <= g_addr;
        wdata_o   <= g_data;
        cold_en_o <= g_cold;
      end
      if (drop_cold)           cold_err_o <= 1'b1;
      else if (cold_err_clr_i) cold_err_o <= 1'b0;
    end
  end

`ifdef COLD_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cold_err_cnt_o <= 8'h00;
    else if (drop_cold)
      cold_err_cnt_o <= cold_err_clr_i ? 8'h01 :
                        (cold_err_cnt_o == 8'hFF) ? 8'hFF : cold_err_cnt_o + 8'h01;
    else if (cold_err_clr_i)
      cold_err_cnt_o <= 8'h00;
  end
`endif
endmodule
